// File: rtl/seq_divider32.sv
// Multi-cycle signed restoring divider: one shift-subtract step per clock.
// Quotient truncates toward zero, remainder takes the sign of the dividend.
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? twos_neg(v) : v;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial  = rem_sh + ~div_q + (WIDTH+1)'(1);

    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (ctrl_div) begin
                    busy_d = 1'b1;
                    negq_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    negr_d = data_operandA[WIDTH-1];
                    ovf_d  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
                    quo_d  = abs_val(data_operandA);
                    div_d  = {1'b0, abs_val(data_operandB)};
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (data_operandB == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? rem_sh : trial;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                result_d    = negq_q ? twos_neg(quo_q) : quo_q;
                remainder_d = negr_q ? twos_neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                exc_d       = ovf_q;
                rdy_d       = 1'b1;
                busy_d      = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                // Divide by zero completes here; stay one more cycle so the ready pulse can drop.
                if (dz_q) begin
                    result_d    = '0;
                    remainder_d = negr_q ? twos_neg(quo_q) : quo_q;
                    exc_d       = 1'b1;
                    rdy_d       = 1'b1;
                    busy_d      = 1'b0;
                    dz_d        = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed-vector bench for seq_divider32 with hand-computed quotients and remainders.
module tb_seq_divider32;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_divider32 #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at the next rising edge and return at the falling edge after it.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_div = 1'b1;
        opa      = a;
        opb      = b;
        @(negedge clock);
        ctrl_div = 1'b0;
        opa      = 32'hDEAD_BEEF;
        opb      = 32'h0000_0001;
    endtask

    task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic ee,
                           input int elat, input int inj);
        int lat;
        start(a, b);
        check({nm, ".busy_start"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (!data_resultRDY && lat < 60) begin
            @(negedge clock);
            lat++;
            if (lat == inj) begin
                ctrl_div = 1'b1;
                opa      = 32'd8;
                opb      = 32'd2;
            end else if (lat == inj + 1) begin
                ctrl_div = 1'b0;
            end
        end
        ctrl_div = 1'b0;
        check({nm, ".latency"}, lat, elat);
        check({nm, ".result"}, data_result, eq);
        check({nm, ".remainder"}, data_remainder, er);
        check({nm, ".exception"}, {31'b0, data_exception}, {31'b0, ee});
        check({nm, ".busy_done"}, {31'b0, busy}, 32'd0);
        @(negedge clock);
        check({nm, ".rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        ctrl_div = 1'b0;
        opa      = '0;
        opb      = '0;
        repeat (2) @(negedge clock);
        check("reset.result", data_result, 32'd0);
        check("reset.remainder", data_remainder, 32'd0);
        check("reset.flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
        reset_n = 1'b1;

        run_div("p100_7",  32'd100,           32'd7,           32'd14,          32'd2,           1'b0, 33, -5);
        run_div("n100_7",  32'hFFFF_FF9C,     32'd7,           32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0, 33, -5);
        run_div("p100_n7", 32'd100,           32'hFFFF_FFF9,   32'hFFFF_FFF2,   32'd2,           1'b0, 33, -5);
        run_div("z_5",     32'd0,             32'd5,           32'd0,           32'd0,           1'b0, 33, -5);
        run_div("div0",    32'd5,             32'd0,           32'd0,           32'd5,           1'b1, 1,  -5);
        run_div("p9_3",    32'd9,             32'd3,           32'd3,           32'd0,           1'b0, 33, -5);
        run_div("div0_neg",32'hFFFF_FFF9,     32'd0,           32'd0,           32'hFFFF_FFF9,   1'b1, 1,  -5);
        run_div("ovf",     32'h8000_0000,     32'hFFFF_FFFF,   32'h8000_0000,   32'd0,           1'b1, 33, -5);
        run_div("min_2",   32'h8000_0000,     32'd2,           32'hC000_0000,   32'd0,           1'b0, 33, -5);
        run_div("n7_n2",   32'hFFFF_FFF9,     32'hFFFF_FFFE,   32'd3,           32'hFFFF_FFFF,   1'b0, 33, -5);

        run_div("ignore",  32'd1000,          32'd10,          32'd100,         32'd0,           1'b0, 33, 4);
        repeat (3) @(negedge clock);
        check("ignore.no_queue_busy", {31'b0, busy}, 32'd0);
        check("ignore.no_queue_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("ignore.hold", data_result, 32'd100);

        start(32'd1000, 32'd10);
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset.result", data_result, 32'd0);
        check("midreset.flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_div("p21_4",   32'd21,            32'd4,           32'd5,           32'd1,           1'b0, 33, -5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
